data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder end of the processor's data-memory interface. It services MemAddr/MemRead/MemWrite/WriteData from the MEM stage and returns MemData in the same cycle, because the MEM stage has no stall path. A secondary host port lets the bench or loader preload and dump the array using a request/grant handshake; that port only gets cycles the processor leaves idle. Address-range and alignment violations are flagged with sticky bits.

Parameters:
ADDR_W, 10, word-index width; array depth = 2**ADDR_W 32-bit words (max 14, so the byte address fits in 16 bits)
RESET_RDATA, 32'h0000_0000, value driven on MemData when no valid read is in progress

Ports:
Clock  input  1  system clock, all state updates on rising edge
nReset  input  1  asynchronous active-low reset
MemAddr  input  16  processor byte address
MemRead  input  1  processor read strobe
MemWrite  input  1  processor write strobe
WriteData  input  32  processor write data
MemData  output  32  processor read data (combinational)
HostReq  input  1  host access request, held until granted
HostWe  input  1  1 = host write, 0 = host read; held with HostReq
HostAddr  input  ADDR_W  host word index
HostWData  input  32  host write data
HostGnt  output  1  host request accepted this cycle (combinational)
HostRData  output  32  registered host read data
HostRValid  output  1  one-cycle pulse, HostRData valid
ErrClr  input  1  clears the sticky error flags
AlignErr  output  1  sticky flag: misaligned processor access
RangeErr  output  1  sticky flag: processor address beyond the array

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low on nReset.
- Array contents are not reset. Reset clears only control state: HostRData=0, HostRValid=0, AlignErr=0, RangeErr=0, FSM=IDLE.
- Processor address decode:
  - Word index = MemAddr[ADDR_W+1:2].
  - Misaligned: MemAddr[1:0] != 0.
  - Out of range: MemAddr[15:ADDR_W+2] != 0.
  - An access is valid when it is neither misaligned nor out of range.
- Processor read: MemData = mem[idx] when MemRead is high and the access is valid; otherwise MemData = RESET_RDATA. Zero latency, purely combinational.
- Processor write: when MemWrite is high and the access is valid, mem[idx] <= WriteData at the rising edge. Invalid writes are dropped.
- MemRead and MemWrite both high: the write commits at the edge, and MemData shows the pre-write contents during that cycle.
- Error flags:
  - AlignErr sets on the edge after any strobed misaligned access.
  - RangeErr sets the same way for any strobed out-of-range access.
  - ErrClr clears both flags.
  - If set and clear coincide in the same cycle, set wins.
- Host FSM has two states, IDLE and RD_RESP.
  - HostGnt = HostReq & (state==IDLE) & ~MemRead & ~MemWrite. Processor priority is absolute.
  - IDLE, granted write: mem[HostAddr] <= HostWData at the edge; FSM stays in IDLE.
  - IDLE, granted read: HostRData <= mem[HostAddr] at the edge; go to RD_RESP.
  - RD_RESP: HostRValid = 1 for exactly this cycle; HostGnt = 0; unconditionally return to IDLE.
  - Host throughput is 1 write per cycle or 1 read per 2 cycles.
  - HostRData holds its last value until the next granted read.
- Host/processor conflict: no conflict is possible, because the host is never granted in a cycle where the processor strobes. A processor write followed by a host read of the same word returns the new data.
- Reset asserted in RD_RESP: FSM goes to IDLE immediately, HostRValid drops asynchronously, and the pending response is lost.
- Host requests are not queued. The host must hold HostReq, HostWe, HostAddr and HostWData stable until HostGnt is sampled high.

Test Plan:
1. Host preload and dump: host writes 0xDEADBEEF to word 5 with no processor activity -> HostGnt=1 in the same cycle; a host read of word 5 -> HostRValid pulses 1 cycle later with HostRData=0xDEADBEEF.
2. Processor write then read: MemWrite to MemAddr=0x0014 with WriteData=0x12345678, then next cycle MemRead to 0x0014 -> MemData=0x12345678 combinationally; MemData=0 in any cycle with MemRead low.
3. Priority: HostReq held for 3 cycles while MemRead is high -> HostGnt=0 for those 3 cycles; grant occurs in the first cycle the processor is idle; the host read then returns the data last written by the processor.
4. Errors: MemWrite to 0x0016 (misaligned) -> word 5 unchanged, AlignErr=1. MemRead to 0x1000 with ADDR_W=10 -> MemData=0, RangeErr=1. ErrClr pulse -> both flags 0. ErrClr coinciding with a new misaligned access -> AlignErr stays 1.
5. Simultaneous strobes: MemRead and MemWrite both high at 0x0014 with old contents 0xA, new data 0xB -> MemData=0xA that cycle, then 0xB on a later read.
6. Reset mid-read: host read granted, then nReset low during RD_RESP -> HostRValid=0 and HostRData=0 immediately; after release, FSM is IDLE, HostGnt=1 on the next request, and array contents are preserved.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Bus bundle between the MEM stage / host loader (master side) and the
// data-memory responder (slave side).
interface data_mem_responder_if #(
  parameter int ADDR_W = 10
);
  logic [15:0]       MemAddr;
  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       WriteData;
  logic [31:0]       MemData;
  logic              HostReq;
  logic              HostWe;
  logic [ADDR_W-1:0] HostAddr;
  logic [31:0]       HostWData;
  logic              HostGnt;
  logic [31:0]       HostRData;
  logic              HostRValid;
  logic              ErrClr;
  logic              AlignErr;
  logic              RangeErr;

  modport master (
    output MemAddr, MemRead, MemWrite, WriteData,
    output HostReq, HostWe, HostAddr, HostWData, ErrClr,
    input  MemData, HostGnt, HostRData, HostRValid, AlignErr, RangeErr
  );

  modport slave (
    input  MemAddr, MemRead, MemWrite, WriteData,
    input  HostReq, HostWe, HostAddr, HostWData, ErrClr,
    output MemData, HostGnt, HostRData, HostRValid, AlignErr, RangeErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: zero-latency processor port with absolute priority,
// plus a host preload/dump port that only uses processor-idle cycles.
module data_mem_responder #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic                 Clock,
  input  logic                 nReset,
  data_mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_RESP = 1'b1
  } state_e;

  logic [31:0]       mem_q [DEPTH];

  state_e            state_q;
  logic [31:0]       host_rdata_q;
  logic              host_rvalid_q;
  logic              align_err_q;
  logic              align_err_d;
  logic              range_err_q;
  logic              range_err_d;

  logic [ADDR_W-1:0] proc_idx_s;
  logic              misalign_s;
  logic              out_of_range_s;
  logic              proc_valid_s;
  logic              proc_strobe_s;
  logic              host_gnt_s;
  logic [31:0]       mem_rdata_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [31:0]       mem_wdata_s;

  // Shift form keeps the range test legal even when ADDR_W+2 reaches 16.
  assign proc_idx_s     = bus.MemAddr[ADDR_W+1:2];
  assign misalign_s     = (bus.MemAddr[1:0] != 2'b00);
  assign out_of_range_s = ((bus.MemAddr >> (ADDR_W + 2)) != 16'h0000);
  assign proc_valid_s   = ~misalign_s & ~out_of_range_s;
  assign proc_strobe_s  = bus.MemRead | bus.MemWrite;
  assign host_gnt_s     = bus.HostReq & (state_q == ST_IDLE) & ~proc_strobe_s;

  // Processor read data, shown before any same-edge write commits.
  always_comb begin
    mem_rdata_s = RESET_RDATA;
    if (bus.MemRead && proc_valid_s) begin
      mem_rdata_s = mem_q[proc_idx_s];
    end else begin
      mem_rdata_s = RESET_RDATA;
    end
  end

  // Single write port: host writes can only be granted when the processor is idle.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = 32'h0000_0000;
    if (bus.MemWrite && proc_valid_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = proc_idx_s;
      mem_wdata_s = bus.WriteData;
    end else if (host_gnt_s && bus.HostWe) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = bus.HostAddr;
      mem_wdata_s = bus.HostWData;
    end else begin
      mem_we_s    = 1'b0;
      mem_waddr_s = '0;
      mem_wdata_s = 32'h0000_0000;
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Sticky error flags: a new violation outranks a clear in the same cycle.
  always_comb begin
    align_err_d = align_err_q;
    range_err_d = range_err_q;
    if (proc_strobe_s && misalign_s) begin
      align_err_d = 1'b1;
    end else if (bus.ErrClr) begin
      align_err_d = 1'b0;
    end else begin
      align_err_d = align_err_q;
    end
    if (proc_strobe_s && out_of_range_s) begin
      range_err_d = 1'b1;
    end else if (bus.ErrClr) begin
      range_err_d = 1'b0;
    end else begin
      range_err_d = range_err_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      align_err_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
      range_err_q <= range_err_d;
    end
  end

  // Host FSM with registered read data and response strobe.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      host_rdata_q  <= 32'h0000_0000;
      host_rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (host_gnt_s && !bus.HostWe) begin
            host_rdata_q  <= mem_q[bus.HostAddr];
            host_rvalid_q <= 1'b1;
            state_q       <= ST_RD_RESP;
          end else begin
            host_rvalid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        ST_RD_RESP: begin
          host_rvalid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: begin
          host_rvalid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.MemData    = mem_rdata_s;
  assign bus.HostGnt    = host_gnt_s;
  assign bus.HostRData  = host_rdata_q;
  assign bus.HostRValid = host_rvalid_q;
  assign bus.AlignErr   = align_err_q;
  assign bus.RangeErr   = range_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: host read data goes through a
// scoreboard queue checked by an independent monitor.
module tb_data_mem_responder;
  logic        clk    = 1'b0;
  logic        nReset = 1'b0;
  int          total  = 0;
  int          bad    = 0;
  logic [31:0] exp_q[$];
  int          n;

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(10)) bus ();

  data_mem_responder #(.ADDR_W(10), .RESET_RDATA(32'h0000_0000)) dut (
    .Clock  (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (nReset && bus.HostRValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL host_rdata: got unexpected pulse %h want none", bus.HostRData);
      end else begin
        check("host_rdata", bus.HostRData, exp_q.pop_front());
      end
    end
  end

  task automatic host_access(input logic we, input logic [9:0] a, input logic [31:0] d,
                             input logic push, output int waited);
    bit granted = 1'b0;
    waited = 0;
    bus.HostReq = 1'b1; bus.HostWe = we; bus.HostAddr = a; bus.HostWData = d;
    for (int i = 0; i < 8 && !granted; i++) begin
      @(negedge clk);
      granted = bus.HostGnt;
      if (granted && !we && push) exp_q.push_back(d);
      if (!granted) waited++;
      tick();
    end
    bus.HostReq = 1'b0; bus.HostWe = 1'b0;
    if (!granted) begin
      total++;
      bad++;
      $display("FAIL host_grant_timeout: got no grant want grant within 8 cycles");
    end
  endtask

  initial begin
    bus.MemAddr = 16'h0000; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.WriteData = 32'h0; bus.HostReq = 1'b0; bus.HostWe = 1'b0;
    bus.HostAddr = 10'd0; bus.HostWData = 32'h0; bus.ErrClr = 1'b0;
    #12;
    check("rst_rvalid", {31'b0, bus.HostRValid}, 32'd0);
    check("rst_rdata", bus.HostRData, 32'h0);
    check("rst_align", {31'b0, bus.AlignErr}, 32'd0);
    check("rst_range", {31'b0, bus.RangeErr}, 32'd0);
    check("rst_memdata", bus.MemData, 32'h0);
    @(negedge clk); nReset = 1'b1;
    tick();

    // Host preload and dump
    host_access(1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, n);
    check("t1_wr_gnt_wait", n, 32'd0);
    host_access(1'b0, 10'd5, 32'hDEAD_BEEF, 1'b1, n);
    check("t1_rd_gnt_wait", n, 32'd0);
    @(negedge clk);
    check("t1_rvalid", {31'b0, bus.HostRValid}, 32'd1);
    tick();
    @(negedge clk);
    check("t1_rvalid_drop", {31'b0, bus.HostRValid}, 32'd0);
    check("t1_rdata_hold", bus.HostRData, 32'hDEAD_BEEF);
    host_access(1'b1, 10'd0, 32'h1111_1111, 1'b0, n);

    // Processor write then read
    bus.MemWrite = 1'b1; bus.MemAddr = 16'h0014; bus.WriteData = 32'h1234_5678;
    @(negedge clk); check("t2_noread_zero", bus.MemData, 32'h0);
    tick(); bus.MemWrite = 1'b0; bus.MemRead = 1'b1;
    @(negedge clk); check("t2_read", bus.MemData, 32'h1234_5678);
    tick(); bus.MemRead = 1'b0;
    @(negedge clk); check("t2_read_low", bus.MemData, 32'h0);
    tick();

    // Priority: host held off while the processor strobes
    bus.HostReq = 1'b1; bus.HostWe = 1'b0; bus.HostAddr = 10'd5;
    bus.MemWrite = 1'b1; bus.MemAddr = 16'h0014; bus.WriteData = 32'h0BAD_F00D;
    @(negedge clk); check("t3_gnt_wr", {31'b0, bus.HostGnt}, 32'd0);
    tick(); bus.MemWrite = 1'b0; bus.MemRead = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_gnt_rd", {31'b0, bus.HostGnt}, 32'd0);
      check("t3_rdata_hold", bus.HostRData, 32'hDEAD_BEEF);
      tick();
    end
    bus.MemRead = 1'b0;
    @(negedge clk); check("t3_gnt_idle", {31'b0, bus.HostGnt}, 32'd1);
    exp_q.push_back(32'h0BAD_F00D);
    tick();
    @(negedge clk); check("t3_gnt_rdresp", {31'b0, bus.HostGnt}, 32'd0);
    bus.HostReq = 1'b0;
    tick();

    // Alignment and range errors
    bus.MemWrite = 1'b1; bus.MemAddr = 16'h0016; bus.WriteData = 32'hFFFF_FFFF;
    tick(); bus.MemWrite = 1'b0;
    @(negedge clk);
    check("t4_align_set", {31'b0, bus.AlignErr}, 32'd1);
    check("t4_range_clear", {31'b0, bus.RangeErr}, 32'd0);
    bus.MemRead = 1'b1; bus.MemAddr = 16'h0014;
    #1 check("t4_word5_kept", bus.MemData, 32'h0BAD_F00D);
    bus.MemAddr = 16'h0016;
    #1 check("t4_misaligned_read", bus.MemData, 32'h0);
    bus.MemAddr = 16'h1000;
    #1 check("t4_range_read", bus.MemData, 32'h0);
    tick(); bus.MemRead = 1'b0;
    @(negedge clk); check("t4_range_set", {31'b0, bus.RangeErr}, 32'd1);
    bus.MemWrite = 1'b1; bus.MemAddr = 16'h1014; bus.WriteData = 32'h0000_0099;
    tick(); bus.MemWrite = 1'b0; bus.MemRead = 1'b1; bus.MemAddr = 16'h0014;
    @(negedge clk); check("t4_range_wr_dropped", bus.MemData, 32'h0BAD_F00D);
    tick(); bus.MemRead = 1'b0; bus.ErrClr = 1'b1;
    tick(); bus.ErrClr = 1'b0;
    @(negedge clk);
    check("t4_align_cleared", {31'b0, bus.AlignErr}, 32'd0);
    check("t4_range_cleared", {31'b0, bus.RangeErr}, 32'd0);
    bus.ErrClr = 1'b1; bus.MemRead = 1'b1; bus.MemAddr = 16'h0001;
    tick(); bus.ErrClr = 1'b0; bus.MemRead = 1'b0;
    @(negedge clk); check("t4_set_beats_clear", {31'b0, bus.AlignErr}, 32'd1);
    bus.ErrClr = 1'b1;
    tick(); bus.ErrClr = 1'b0;

    // Simultaneous read and write
    bus.MemWrite = 1'b1; bus.MemAddr = 16'h0014; bus.WriteData = 32'h0000_000A;
    tick(); bus.MemRead = 1'b1; bus.WriteData = 32'h0000_000B;
    @(negedge clk); check("t5_pre_write_data", bus.MemData, 32'h0000_000A);
    tick(); bus.MemWrite = 1'b0;
    @(negedge clk); check("t5_new_data", bus.MemData, 32'h0000_000B);
    tick(); bus.MemRead = 1'b0;

    // Reset during a pending host response
    host_access(1'b0, 10'd0, 32'h1111_1111, 1'b0, n);
    nReset = 1'b0;
    #1;
    check("t6_rvalid_async", {31'b0, bus.HostRValid}, 32'd0);
    check("t6_rdata_async", bus.HostRData, 32'h0);
    @(negedge clk); nReset = 1'b1;
    tick();
    host_access(1'b0, 10'd5, 32'h0000_000B, 1'b1, n);
    check("t6_gnt_after_reset", n, 32'd0);
    @(negedge clk);
    bus.MemRead = 1'b1; bus.MemAddr = 16'h0000;
    #1 check("t6_word0_kept", bus.MemData, 32'h1111_1111);
    tick(); bus.MemRead = 1'b0;

    repeat (3) tick();
    check("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
